// File: rtl/ysyx_25020037_dec_pkg.sv
// Shared decode constants: opcodes, funct7 values, one-hot ALU/ctrl bit positions, entry width.
// The RV32M decode path is enabled by defining DEC_RV32M_EN.
package ysyx_25020037_dec_pkg;

   localparam logic [6:0] OPC_LUI    = 7'h37;
   localparam logic [6:0] OPC_AUIPC  = 7'h17;
   localparam logic [6:0] OPC_JAL    = 7'h6F;
   localparam logic [6:0] OPC_JALR   = 7'h67;
   localparam logic [6:0] OPC_BRANCH = 7'h63;
   localparam logic [6:0] OPC_LOAD   = 7'h03;
   localparam logic [6:0] OPC_STORE  = 7'h23;
   localparam logic [6:0] OPC_OPIMM  = 7'h13;
   localparam logic [6:0] OPC_OP     = 7'h33;
   localparam logic [6:0] OPC_MISC   = 7'h0F;
   localparam logic [6:0] OPC_SYSTEM = 7'h73;

   localparam logic [6:0] F7_BASE   = 7'h00;
   localparam logic [6:0] F7_ALT    = 7'h20;
   localparam logic [6:0] F7_MULDIV = 7'h01;

   localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
   localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
   localparam logic [31:0] INST_MRET   = 32'h3020_0073;

   localparam int ALU_ADD  = 0;
   localparam int ALU_SUB  = 1;
   localparam int ALU_SLT  = 2;
   localparam int ALU_SLTU = 3;
   localparam int ALU_AND  = 4;
   localparam int ALU_OR   = 5;
   localparam int ALU_XOR  = 6;
   localparam int ALU_SLL  = 7;
   localparam int ALU_SRL  = 8;
   localparam int ALU_SRA  = 9;
   localparam int ALU_LUI  = 10;
   localparam int ALU_BNE  = 11;
   localparam int ALU_BEQ  = 12;
   localparam int ALU_BGE  = 13;
   localparam int ALU_BGEU = 14;
   localparam int ALU_BLT  = 15;
   localparam int ALU_BLTU = 16;
   localparam int ALU_OP_W = 17;

   localparam int CTRL_ST       = 0;
   localparam int CTRL_LD       = 1;
   localparam int CTRL_GPR_WE   = 2;
   localparam int CTRL_SRC1_PC  = 3;
   localparam int CTRL_SRC2_IMM = 4;
   localparam int CTRL_PC_JUMP  = 5;
   localparam int CTRL_EBREAK   = 6;
   localparam int CTRL_ECALL    = 7;
   localparam int CTRL_MRET     = 8;
   localparam int CTRL_CSRRS    = 9;
   localparam int CTRL_CSRRW    = 10;
   localparam int CTRL_FENCE_I  = 11;
   localparam int CTRL_W        = 12;

   localparam int MUL_OP_W = 8;

   typedef enum logic [2:0] {
      IMM_N, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_Z
   } imm_sel_e;

   // Packed entry: {pc, imm, rd, rs1, rs2, alu_op, ctrl, funct3, illeg}; mul_op is stored separately.
   function automatic int uop_w(input int xlen, input int reg_aw, input int alu_w);
      return 2 * xlen + 3 * reg_aw + alu_w + CTRL_W + 4;
   endfunction

   localparam int UOP_W = uop_w(32, 4, ALU_OP_W);

endpackage

// File: rtl/ysyx_25020037_dec_logic.sv
// Combinational RV32I/E instruction -> micro-op decoder.
// DEC_RV32M_EN adds the mul_op_o port and decodes the M-extension OP encodings.
module ysyx_25020037_dec_logic
   import ysyx_25020037_dec_pkg::*;
#(
   parameter int XLEN     = 32,
   parameter int REG_AW   = 4,
   parameter int ALU_OP_W = 17
) (
   input  logic [31:0]         inst_i,
   output logic [XLEN-1:0]     imm_o,
   output logic [REG_AW-1:0]   rd_o,
   output logic [REG_AW-1:0]   rs1_o,
   output logic [REG_AW-1:0]   rs2_o,
   output logic [ALU_OP_W-1:0] alu_op_o,
`ifdef DEC_RV32M_EN
   output logic [MUL_OP_W-1:0] mul_op_o,
`endif
   output logic [CTRL_W-1:0]   ctrl_o,
   output logic [2:0]          funct3_o,
   output logic                illeg_o
);

   logic [6:0]            opc;
   logic [2:0]            f3;
   logic [6:0]            f7;
   imm_sel_e              imm_sel;
   logic [31:0]           imm32;
   logic [ALU_OP_W-1:0]   alu;
   logic [MUL_OP_W-1:0]   mul;
   logic [CTRL_W-1:0]     ctrl;
   logic                  illeg;
   logic                  use_rd, use_rs1, use_rs2;

   assign opc      = inst_i[6:0];
   assign f3       = inst_i[14:12];
   assign f7       = inst_i[31:25];
   assign rd_o     = inst_i[7 +: REG_AW];
   assign rs1_o    = inst_i[15 +: REG_AW];
   assign rs2_o    = inst_i[20 +: REG_AW];
   assign funct3_o = f3;

   always_comb begin
      imm_sel = IMM_N;
      alu     = '0;
      mul     = '0;
      ctrl    = '0;
      illeg   = 1'b0;
      use_rd  = 1'b0;
      use_rs1 = 1'b0;
      use_rs2 = 1'b0;
      unique case (opc)
         OPC_LUI: begin
            imm_sel = IMM_U;  use_rd = 1'b1;  alu[ALU_LUI] = 1'b1;
            ctrl[CTRL_GPR_WE] = 1'b1;  ctrl[CTRL_SRC2_IMM] = 1'b1;
         end
         OPC_AUIPC: begin
            imm_sel = IMM_U;  use_rd = 1'b1;  alu[ALU_ADD] = 1'b1;
            ctrl[CTRL_GPR_WE] = 1'b1;  ctrl[CTRL_SRC1_PC] = 1'b1;  ctrl[CTRL_SRC2_IMM] = 1'b1;
         end
         OPC_JAL: begin
            imm_sel = IMM_J;  use_rd = 1'b1;  alu[ALU_ADD] = 1'b1;
            ctrl[CTRL_GPR_WE] = 1'b1;  ctrl[CTRL_SRC1_PC] = 1'b1;
            ctrl[CTRL_SRC2_IMM] = 1'b1;  ctrl[CTRL_PC_JUMP] = 1'b1;
         end
         OPC_JALR: begin
            imm_sel = IMM_I;  use_rd = 1'b1;  use_rs1 = 1'b1;  alu[ALU_ADD] = 1'b1;
            ctrl[CTRL_GPR_WE] = 1'b1;  ctrl[CTRL_SRC2_IMM] = 1'b1;  ctrl[CTRL_PC_JUMP] = 1'b1;
            illeg = (f3 != 3'b000);
         end
         OPC_BRANCH: begin
            imm_sel = IMM_B;  use_rs1 = 1'b1;  use_rs2 = 1'b1;
            ctrl[CTRL_SRC1_PC] = 1'b1;  ctrl[CTRL_SRC2_IMM] = 1'b1;  ctrl[CTRL_PC_JUMP] = 1'b1;
            case (f3)
               3'b000:  alu[ALU_BEQ]  = 1'b1;
               3'b001:  alu[ALU_BNE]  = 1'b1;
               3'b100:  alu[ALU_BLT]  = 1'b1;
               3'b101:  alu[ALU_BGE]  = 1'b1;
               3'b110:  alu[ALU_BLTU] = 1'b1;
               3'b111:  alu[ALU_BGEU] = 1'b1;
               default: illeg = 1'b1;
            endcase
         end
         OPC_LOAD: begin
            imm_sel = IMM_I;  use_rd = 1'b1;  use_rs1 = 1'b1;  alu[ALU_ADD] = 1'b1;
            ctrl[CTRL_GPR_WE] = 1'b1;  ctrl[CTRL_SRC2_IMM] = 1'b1;  ctrl[CTRL_LD] = 1'b1;
            illeg = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
         end
         OPC_STORE: begin
            imm_sel = IMM_S;  use_rs1 = 1'b1;  use_rs2 = 1'b1;  alu[ALU_ADD] = 1'b1;
            ctrl[CTRL_SRC2_IMM] = 1'b1;  ctrl[CTRL_ST] = 1'b1;
            illeg = (f3[2] == 1'b1) || (f3 == 3'b011);
         end
         OPC_OPIMM: begin
            imm_sel = IMM_I;  use_rd = 1'b1;  use_rs1 = 1'b1;
            ctrl[CTRL_GPR_WE] = 1'b1;  ctrl[CTRL_SRC2_IMM] = 1'b1;
            case (f3)
               3'b000: alu[ALU_ADD]  = 1'b1;
               3'b010: alu[ALU_SLT]  = 1'b1;
               3'b011: alu[ALU_SLTU] = 1'b1;
               3'b100: alu[ALU_XOR]  = 1'b1;
               3'b110: alu[ALU_OR]   = 1'b1;
               3'b111: alu[ALU_AND]  = 1'b1;
               3'b001: if (f7 == F7_BASE) alu[ALU_SLL] = 1'b1; else illeg = 1'b1;
               default: begin
                  if (f7 == F7_BASE)     alu[ALU_SRL] = 1'b1;
                  else if (f7 == F7_ALT) alu[ALU_SRA] = 1'b1;
                  else                   illeg = 1'b1;
               end
            endcase
         end
         OPC_OP: begin
            use_rd = 1'b1;  use_rs1 = 1'b1;  use_rs2 = 1'b1;  ctrl[CTRL_GPR_WE] = 1'b1;
            if (f7 == F7_BASE) begin
               case (f3)
                  3'b000: alu[ALU_ADD]  = 1'b1;
                  3'b001: alu[ALU_SLL]  = 1'b1;
                  3'b010: alu[ALU_SLT]  = 1'b1;
                  3'b011: alu[ALU_SLTU] = 1'b1;
                  3'b100: alu[ALU_XOR]  = 1'b1;
                  3'b101: alu[ALU_SRL]  = 1'b1;
                  3'b110: alu[ALU_OR]   = 1'b1;
                  default: alu[ALU_AND] = 1'b1;
               endcase
            end else if (f7 == F7_ALT && f3 == 3'b000) begin
               alu[ALU_SUB] = 1'b1;
            end else if (f7 == F7_ALT && f3 == 3'b101) begin
               alu[ALU_SRA] = 1'b1;
            end else if (f7 == F7_MULDIV) begin
`ifdef DEC_RV32M_EN
               mul[f3] = 1'b1;
`else
               illeg = 1'b1;
`endif
            end else begin
               illeg = 1'b1;
            end
         end
         OPC_MISC: begin
            if (f3 == 3'b001)      ctrl[CTRL_FENCE_I] = 1'b1;
            else if (f3 != 3'b000) illeg = 1'b1;
         end
         OPC_SYSTEM: begin
            if (inst_i == INST_ECALL) begin
               ctrl[CTRL_ECALL] = 1'b1;  ctrl[CTRL_PC_JUMP] = 1'b1;
            end else if (inst_i == INST_EBREAK) begin
               ctrl[CTRL_EBREAK] = 1'b1;
            end else if (inst_i == INST_MRET) begin
               ctrl[CTRL_MRET] = 1'b1;  ctrl[CTRL_PC_JUMP] = 1'b1;
            end else if (f3 == 3'b001 || f3 == 3'b010) begin
               imm_sel = IMM_Z;  use_rd = 1'b1;  use_rs1 = 1'b1;  ctrl[CTRL_GPR_WE] = 1'b1;
               ctrl[CTRL_CSRRW] = (f3 == 3'b001);
               ctrl[CTRL_CSRRS] = (f3 == 3'b010);
            end else begin
               illeg = 1'b1;
            end
         end
         default: illeg = 1'b1;
      endcase
      // RV32E has only x0..x15: a used register field with bit 4 set cannot be executed.
      if (REG_AW == 4 && ((use_rd && inst_i[11]) || (use_rs1 && inst_i[19]) || (use_rs2 && inst_i[24])))
         illeg = 1'b1;
      if (illeg) begin
         alu  = '0;
         mul  = '0;
         ctrl = '0;
      end
   end

   always_comb begin
      unique case (imm_sel)
         IMM_I:   imm32 = {{20{inst_i[31]}}, inst_i[31:20]};
         IMM_S:   imm32 = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
         IMM_B:   imm32 = {{20{inst_i[31]}}, inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
         IMM_U:   imm32 = {inst_i[31:12], 12'b0};
         IMM_J:   imm32 = {{12{inst_i[31]}}, inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};
         IMM_Z:   imm32 = {20'b0, inst_i[31:20]};
         default: imm32 = '0;
      endcase
   end

   assign imm_o    = XLEN'($signed(imm32));
   assign alu_op_o = alu;
   assign ctrl_o   = ctrl;
   assign illeg_o  = illeg;
`ifdef DEC_RV32M_EN
   assign mul_op_o = mul;
`endif

endmodule

// File: rtl/ysyx_25020037_dec_queue.sv
// Decode stage: decodes IFU instructions and buffers micro-ops in a DEPTH-entry FIFO toward the EXU.
// DEC_RV32M_EN enables M-extension decode and the mul_op storage; otherwise out_mul_op is tied 0.
module ysyx_25020037_dec_queue
   import ysyx_25020037_dec_pkg::*;
#(
   parameter int XLEN     = 32,
   parameter int DEPTH    = 2,
   parameter int REG_AW   = 4,
   parameter int ALU_OP_W = 17
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [XLEN-1:0]          in_pc,
   input  logic [31:0]              in_inst,
   input  logic                     flush,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [XLEN-1:0]          out_pc,
   output logic [XLEN-1:0]          out_imm,
   output logic [REG_AW-1:0]        out_rd,
   output logic [REG_AW-1:0]        out_rs1,
   output logic [REG_AW-1:0]        out_rs2,
   output logic [ALU_OP_W-1:0]      out_alu_op,
   output logic [7:0]               out_mul_op,
   output logic [11:0]              out_ctrl,
   output logic [2:0]               out_funct3,
   output logic                     out_illeg,
   output logic [$clog2(DEPTH):0]   out_count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam int EW = uop_w(XLEN, REG_AW, ALU_OP_W);

   logic [XLEN-1:0]     d_imm;
   logic [REG_AW-1:0]   d_rd, d_rs1, d_rs2;
   logic [ALU_OP_W-1:0] d_alu;
   logic [CTRL_W-1:0]   d_ctrl;
   logic [2:0]          d_f3;
   logic                d_illeg;

   logic [EW-1:0]       mem_q [DEPTH];
   logic [EW-1:0]       entry_d;
   logic [PW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]       count_q, count_d;
   logic                enq, deq;

`ifdef DEC_RV32M_EN
   logic [MUL_OP_W-1:0] d_mul;
   logic [MUL_OP_W-1:0] mul_q [DEPTH];
`endif

   ysyx_25020037_dec_logic #(
      .XLEN     (XLEN),
      .REG_AW   (REG_AW),
      .ALU_OP_W (ALU_OP_W)
   ) u_dec (
      .inst_i   (in_inst),
      .imm_o    (d_imm),
      .rd_o     (d_rd),
      .rs1_o    (d_rs1),
      .rs2_o    (d_rs2),
      .alu_op_o (d_alu),
`ifdef DEC_RV32M_EN
      .mul_op_o (d_mul),
`endif
      .ctrl_o   (d_ctrl),
      .funct3_o (d_f3),
      .illeg_o  (d_illeg)
   );

   // No full-FIFO bypass: a full queue refuses input even while the head is being drained.
   assign in_ready  = (count_q != CW'(DEPTH)) && !flush;
   assign out_valid = (count_q != '0) && !flush;
   assign enq       = in_valid && in_ready;
   assign deq       = out_valid && out_ready;
   assign out_count = count_q;
   assign entry_d   = {in_pc, d_imm, d_rd, d_rs1, d_rs2, d_alu, d_ctrl, d_f3, d_illeg};

   assign {out_pc, out_imm, out_rd, out_rs1, out_rs2, out_alu_op, out_ctrl, out_funct3, out_illeg} =
      mem_q[rd_ptr_q];
`ifdef DEC_RV32M_EN
   assign out_mul_op = mul_q[rd_ptr_q];
`else
   assign out_mul_op = '0;
`endif

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (enq) wr_ptr_d = wr_ptr_q + PW'(1);
         if (deq) rd_ptr_d = rd_ptr_q + PW'(1);
         if (enq && !deq)      count_d = count_q + CW'(1);
         else if (!enq && deq) count_d = count_q - CW'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
`ifdef DEC_RV32M_EN
            mul_q[i] <= '0;
`endif
         end
      end else if (enq) begin
         mem_q[wr_ptr_q] <= entry_d;
`ifdef DEC_RV32M_EN
         mul_q[wr_ptr_q] <= d_mul;
`endif
      end
   end

endmodule

// File: tb/tb_ysyx_25020037_dec_queue.sv
// Directed bench for the decode queue: handshakes, ordering, flush, reset, and decode of key encodings.
module tb_ysyx_25020037_dec_queue;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid, flush, out_ready;
   logic [31:0] in_pc, in_inst;

   logic        in_ready, out_valid, out_illeg;
   logic [31:0] out_pc, out_imm;
   logic [3:0]  out_rd, out_rs1, out_rs2;
   logic [16:0] out_alu_op;
   logic [7:0]  out_mul_op;
   logic [11:0] out_ctrl;
   logic [2:0]  out_funct3;
   logic [1:0]  out_count;

   logic        in_ready5, out_valid5, out_illeg5;
   logic [31:0] out_pc5, out_imm5;
   logic [4:0]  out_rd5, out_rs15, out_rs25;
   logic [16:0] out_alu_op5;
   logic [7:0]  out_mul_op5;
   logic [11:0] out_ctrl5;
   logic [2:0]  out_funct35;
   logic [1:0]  out_count5;

   int npass = 0;
   int ntotal = 0;

   always #5 clk = ~clk;

   ysyx_25020037_dec_queue #(.XLEN(32), .DEPTH(2), .REG_AW(4), .ALU_OP_W(17)) u_dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
      .in_inst(in_inst), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
      .out_pc(out_pc), .out_imm(out_imm), .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
      .out_alu_op(out_alu_op), .out_mul_op(out_mul_op), .out_ctrl(out_ctrl),
      .out_funct3(out_funct3), .out_illeg(out_illeg), .out_count(out_count)
   );

   ysyx_25020037_dec_queue #(.XLEN(32), .DEPTH(2), .REG_AW(5), .ALU_OP_W(17)) u_dut5 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready5), .in_pc(in_pc),
      .in_inst(in_inst), .flush(flush), .out_valid(out_valid5), .out_ready(out_ready),
      .out_pc(out_pc5), .out_imm(out_imm5), .out_rd(out_rd5), .out_rs1(out_rs15), .out_rs2(out_rs25),
      .out_alu_op(out_alu_op5), .out_mul_op(out_mul_op5), .out_ctrl(out_ctrl5),
      .out_funct3(out_funct35), .out_illeg(out_illeg5), .out_count(out_count5)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      ntotal++;
      assert (obs === exp) npass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1;  in_valid = 1'b0;  flush = 1'b0;  out_ready = 1'b0;
      in_pc = '0;  in_inst = '0;
      #3;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_count", out_count, 0);
      chk("rst_pc", out_pc, 0);
      chk("rst_imm", out_imm, 0);
      chk("rst_alu", out_alu_op, 0);
      tick();  tick();
      rst = 1'b0;

      // addi x1,x2,-1
      in_valid = 1'b1;  in_pc = 32'h8000_0000;  in_inst = 32'hFFF1_0093;
      #1;
      chk("t1_in_ready", in_ready, 1);
      chk("t1_valid_before", out_valid, 0);
      tick();
      in_valid = 1'b0;
      #1;
      chk("t1_valid", out_valid, 1);
      chk("t1_count", out_count, 1);
      chk("t1_pc", out_pc, 32'h8000_0000);
      chk("t1_imm", out_imm, 32'hFFFF_FFFF);
      chk("t1_rd", out_rd, 1);
      chk("t1_rs1", out_rs1, 2);
      chk("t1_alu", out_alu_op, 17'h1);
      chk("t1_ctrl", out_ctrl, 12'h014);
      chk("t1_illeg", out_illeg, 0);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      #1;
      chk("t1_drain_count", out_count, 0);
      chk("t1_drain_valid", out_valid, 0);

      // fill to full, third instruction stalls, drain in order
      in_valid = 1'b1;  in_pc = 32'h100;  in_inst = 32'h0050_0193;  // addi x3,x0,5
      tick();
      in_pc = 32'h104;  in_inst = 32'h0020_8233;                    // add x4,x1,x2
      #1;
      chk("t2_ready_2nd", in_ready, 1);
      tick();
      in_pc = 32'h108;  in_inst = 32'h1234_52B7;                    // lui x5,0x12345
      #1;
      chk("t2_full_ready", in_ready, 0);
      chk("t2_full_count", out_count, 2);
      tick();
      chk("t2_stall_count", out_count, 2);
      chk("t2_head_a", out_pc, 32'h100);
      chk("t2_imm_a", out_imm, 5);
      out_ready = 1'b1;
      #1;
      chk("t2_nobypass", in_ready, 0);
      tick();
      chk("t2_count_after1", out_count, 1);
      chk("t2_head_b", out_pc, 32'h104);
      chk("t2_alu_b", out_alu_op, 17'h1);
      chk("t2_imm_b", out_imm, 0);
      chk("t2_ready_b", in_ready, 1);
      tick();
      in_valid = 1'b0;
      #1;
      chk("t2_count_c", out_count, 1);
      chk("t2_head_c", out_pc, 32'h108);
      chk("t2_alu_c", out_alu_op, 17'h400);
      chk("t2_imm_c", out_imm, 32'h1234_5000);
      chk("t2_ctrl_c", out_ctrl, 12'h014);
      chk("t2_rd_c", out_rd, 5);
      tick();
      out_ready = 1'b0;
      chk("t2_empty", out_valid, 0);

      // flush with full queue and a pending input
      in_valid = 1'b1;  in_pc = 32'h200;  in_inst = 32'h0050_0193;
      tick();
      in_pc = 32'h204;
      tick();
      chk("t3_full", out_count, 2);
      flush = 1'b1;  in_pc = 32'h208;
      #1;
      chk("t3_flush_ready", in_ready, 0);
      chk("t3_flush_valid", out_valid, 0);
      tick();
      flush = 1'b0;  in_valid = 1'b0;
      #1;
      chk("t3_count", out_count, 0);
      chk("t3_valid", out_valid, 0);
      chk("t3_ready", in_ready, 1);

      // streaming with one entry resident
      in_valid = 1'b1;  in_pc = 32'h300;  in_inst = 32'h0050_0193;
      tick();
      out_ready = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         in_pc = 32'h300 + 32'(4 * i);
         #1;
         chk("t4_head", out_pc, 32'h300 + 32'(4 * (i - 1)));
         tick();
         chk("t4_count", out_count, 1);
      end
      in_valid = 1'b0;
      #1;
      chk("t4_last", out_pc, 32'h310);
      tick();
      out_ready = 1'b0;
      chk("t4_empty", out_count, 0);

      // mul x3,x1,x2
      in_valid = 1'b1;  in_pc = 32'h400;  in_inst = 32'h0220_81B3;
      tick();
      in_valid = 1'b0;
      #1;
`ifdef DEC_RV32M_EN
      chk("t5_illeg", out_illeg, 0);
      chk("t5_mul", out_mul_op, 8'h01);
      chk("t5_ctrl", out_ctrl, 12'h004);
`else
      chk("t5_illeg", out_illeg, 1);
      chk("t5_mul", out_mul_op, 8'h00);
      chk("t5_ctrl", out_ctrl, 12'h000);
`endif
      chk("t5_alu", out_alu_op, 0);
      chk("t5_valid", out_valid, 1);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;

      // add x16,x1,x2: illegal on RV32E, legal on RV32I
      in_valid = 1'b1;  in_pc = 32'h500;  in_inst = 32'h0020_8833;
      tick();
      in_valid = 1'b0;
      #1;
      chk("t6_e_illeg", out_illeg, 1);
      chk("t6_e_ctrl", out_ctrl, 0);
      chk("t6_e_alu", out_alu_op, 0);
      chk("t6_e_pc", out_pc, 32'h500);
      chk("t6_i_illeg", out_illeg5, 0);
      chk("t6_i_rd", out_rd5, 16);
      chk("t6_i_ctrl", out_ctrl5, 12'h004);
      chk("t6_i_alu", out_alu_op5, 17'h1);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;

      // bne x1,x2,-4
      in_valid = 1'b1;  in_pc = 32'h600;  in_inst = 32'hFE20_9EE3;
      tick();
      in_valid = 1'b0;
      #1;
      chk("t7_imm", out_imm, 32'hFFFF_FFFC);
      chk("t7_alu", out_alu_op, 17'h0800);
      chk("t7_ctrl", out_ctrl, 12'h038);
      chk("t7_rs1", out_rs1, 1);
      chk("t7_rs2", out_rs2, 2);
      chk("t7_f3", out_funct3, 1);

      // asynchronous reset mid-operation
      rst = 1'b1;
      #1;
      chk("t8_count", out_count, 0);
      chk("t8_valid", out_valid, 0);
      chk("t8_pc", out_pc, 0);
      chk("t8_ready", in_ready, 1);
      tick();
      rst = 1'b0;
      tick();

      $display("%0d/%0d checks passed", npass, ntotal);
      $finish;
   end

endmodule
